// File: rtl/montgomery_mul_if.sv
// montgomery_mul_if: request/operand/result bundle for the Montgomery multiplier
interface montgomery_mul_if #(parameter int WIDTH = 256);
    logic             i_start;
    logic [WIDTH-1:0] i_N;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] o_m;
    logic             o_done;
    logic             o_busy;
    modport master (output i_start, i_N, i_a, i_b, input o_m, o_done, o_busy);
    modport slave  (input i_start, i_N, i_a, i_b, output o_m, o_done, o_busy);
endinterface

// File: rtl/montgomery_mul.sv
// montgomery_mul: iterative radix-2 Montgomery multiplier, o_m = a*b*2^(-WIDTH) mod N
module montgomery_mul #(
    parameter int WIDTH          = 256,
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    montgomery_mul_if.slave  bus
);
    localparam int STEPS = WIDTH / ITER_PER_CYCLE;
    localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_n, r_a, r_b, r_m_out;
    logic [WIDTH+1:0] r_m, w_m_next;
    logic [WIDTH-1:0] w_m_fix;
    logic             w_last;
    // r_a shifts right each cycle so the current multiplier bits sit at the bottom
    always_comb begin
        w_m_next = r_m;
        for (int s = 0; s < ITER_PER_CYCLE; s++) begin
            w_m_next = w_m_next + (r_a[s] ? {2'b00, r_b} : '0);
            w_m_next = w_m_next + (w_m_next[0] ? {2'b00, r_n} : '0);
            w_m_next = w_m_next >> 1;
        end
    end
    assign w_last  = r_cnt == CW'(STEPS - 1);
    assign w_m_fix = r_m >= {2'b00, r_n} ? WIDTH'(r_m - {2'b00, r_n}) : r_m[WIDTH-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_m_out <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.i_start) begin
                    r_n     <= bus.i_N;
                    r_a     <= bus.i_a;
                    r_b     <= bus.i_b;
                    r_m     <= '0;
                    r_cnt   <= '0;
                    r_state <= CALC;
                end
                CALC: begin
                    r_m     <= w_m_next;
                    r_a     <= r_a >> ITER_PER_CYCLE;
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= w_last ? FIX : CALC;
                end
                FIX: begin
                    r_m_out <= w_m_fix;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.o_m    = r_m_out;
    assign bus.o_done = r_state == DONE;
    assign bus.o_busy = r_state == CALC || r_state == FIX;
endmodule

// File: tb/tb_montgomery_mul.sv
// tb_montgomery_mul: directed and golden-checked tests for montgomery_mul at W=8 (ITER 1/2/4) and W=256
module tb_montgomery_mul;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    int tests_run = 0, failed = 0;
    logic [2:0] st8 = '0;
    logic [7:0] n8 = '0, a8 = '0, b8 = '0;
    logic st256 = 0;
    logic [255:0] n256 = '0, a256 = '0, b256 = '0;
    montgomery_mul_if #(.WIDTH(8))   bus81 ();
    montgomery_mul_if #(.WIDTH(8))   bus82 ();
    montgomery_mul_if #(.WIDTH(8))   bus84 ();
    montgomery_mul_if #(.WIDTH(256)) bus256 ();
    montgomery_mul #(.WIDTH(8),   .ITER_PER_CYCLE(1)) dut81  (.clk(clk), .rst_n(rst_n), .bus(bus81));
    montgomery_mul #(.WIDTH(8),   .ITER_PER_CYCLE(2)) dut82  (.clk(clk), .rst_n(rst_n), .bus(bus82));
    montgomery_mul #(.WIDTH(8),   .ITER_PER_CYCLE(4)) dut84  (.clk(clk), .rst_n(rst_n), .bus(bus84));
    montgomery_mul #(.WIDTH(256), .ITER_PER_CYCLE(1)) dut256 (.clk(clk), .rst_n(rst_n), .bus(bus256));
    assign bus81.i_start = st8[0];
    assign bus82.i_start = st8[1];
    assign bus84.i_start = st8[2];
    assign {bus81.i_N, bus81.i_a, bus81.i_b} = {n8, a8, b8};
    assign {bus82.i_N, bus82.i_a, bus82.i_b} = {n8, a8, b8};
    assign {bus84.i_N, bus84.i_a, bus84.i_b} = {n8, a8, b8};
    assign bus256.i_start = st256;
    assign {bus256.i_N, bus256.i_a, bus256.i_b} = {n256, a256, b256};
    logic [2:0] done8, busy8;
    logic [7:0] m8 [3];
    assign done8 = {bus84.o_done, bus82.o_done, bus81.o_done};
    assign busy8 = {bus84.o_busy, bus82.o_busy, bus81.o_busy};
    assign m8[0] = bus81.o_m;
    assign m8[1] = bus82.o_m;
    assign m8[2] = bus84.o_m;

    // edges counts rising edges including the one that samples start; -1 on timeout
    task automatic run8(input int sel, input logic [7:0] n, a, b,
                        output logic [7:0] m, output int edges, output int busy_n);
        @(negedge clk);
        n8 = n; a8 = a; b8 = b; st8[sel] = 1'b1;
        @(posedge clk);
        edges = 1; busy_n = 0;
        @(negedge clk);
        st8[sel] = 1'b0;
        forever begin
            busy_n += int'(busy8[sel]);
            if (done8[sel]) break;
            if (edges >= 400) begin edges = -1; break; end
            @(posedge clk); edges++;
            @(negedge clk);
        end
        m = m8[sel];
    endtask

    task automatic run256(input logic [255:0] n, a, b, output logic [255:0] m, output int edges);
        @(negedge clk);
        n256 = n; a256 = a; b256 = b; st256 = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        st256 = 1'b0;
        forever begin
            if (bus256.o_done) break;
            if (edges >= 400) begin edges = -1; break; end
            @(posedge clk); edges++;
            @(negedge clk);
        end
        m = bus256.o_m;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 0;
        #3;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({m8[i], done8[i], busy8[i]} !== 10'b0) begin
                failed++;
                $display("FAIL reset8[%0d]: got m=%0d done=%b busy=%b, need 0/0/0", i, m8[i], done8[i], busy8[i]);
            end
        end
        tests_run++;
        if ({bus256.o_m, bus256.o_done, bus256.o_busy} !== 258'b0) begin
            failed++;
            $display("FAIL reset256: got m=%h done=%b busy=%b, need 0", bus256.o_m, bus256.o_done, bus256.o_busy);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();
        logic [7:0] m;
        int e, bz;
        logic [7:0] va [5] = '{8'd5, 8'd12, 8'd0, 8'd1, 8'd3};
        logic [7:0] vb [5] = '{8'd7, 8'd12, 8'd9, 8'd9, 8'd4};
        logic [7:0] vm [5] = '{8'd1, 8'd3,  8'd0, 8'd1, 8'd10};
        for (int i = 0; i < 5; i++) begin
            run8(0, 8'd13, va[i], vb[i], m, e, bz);
            tests_run++;
            if (m !== vm[i] || e != 10) begin
                failed++;
                $display("FAIL basic a=%0d b=%0d: got m=%0d lat=%0d, need m=%0d lat=10", va[i], vb[i], m, e, vm[i]);
            end
            if (i == 0) begin
                tests_run++;
                if (bz != 9) begin
                    failed++;
                    $display("FAIL busy_len: got %0d cycles, need 9", bz);
                end
            end
        end
        @(negedge clk);
        tests_run++;
        if (done8[0] !== 1'b0) begin
            failed++;
            $display("FAIL done_pulse: got done=%b one cycle after, need 0", done8[0]);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (m8[0] !== 8'd10 || busy8[0] !== 1'b0) begin
            failed++;
            $display("FAIL hold: got m=%0d busy=%b, need m=10 busy=0", m8[0], busy8[0]);
        end
    endtask

    task automatic test_iter();
        logic [7:0] m;
        int e, bz;
        for (int s = 1; s < 3; s++) begin
            run8(s, 8'd13, 8'd5, 8'd7, m, e, bz);
            tests_run++;
            if (m !== 8'd1 || e != (s == 1 ? 6 : 4)) begin
                failed++;
                $display("FAIL iter%0d 5*7: got m=%0d lat=%0d, need m=1 lat=%0d", 1 << s, m, e, s == 1 ? 6 : 4);
            end
            run8(s, 8'd13, 8'd12, 8'd12, m, e, bz);
            tests_run++;
            if (m !== 8'd3) begin
                failed++;
                $display("FAIL iter%0d 12*12: got m=%0d, need 3", 1 << s, m);
            end
        end
    endtask

    task automatic test_ignore_start();
        int edges = 1, dones = 0, lat = -1;
        logic [7:0] got = '0;
        @(negedge clk);
        n8 = 13; a8 = 5; b8 = 7; st8[0] = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done8[0]) begin dones++; got = m8[0]; lat = edges; end
            if (k == 2) a8 = 12;
            if (k == 5) b8 = 1;
            st8[0] = (k == 3 || k == 9 || done8[0]);
            @(posedge clk); edges++;
        end
        @(negedge clk);
        st8[0] = 1'b0;
        tests_run++;
        if (dones != 1 || got !== 8'd1 || lat != 10) begin
            failed++;
            $display("FAIL ignore_start: got dones=%0d m=%0d lat=%0d, need 1/1/10", dones, got, lat);
        end
        tests_run++;
        if (busy8[0] !== 1'b0 || m8[0] !== 8'd1) begin
            failed++;
            $display("FAIL start_in_done: got busy=%b m=%0d, need busy=0 m=1", busy8[0], m8[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1, m2;
        int e1, e2, bz;
        run8(0, 8'd13, 8'd12, 8'd12, m1, e1, bz);
        run8(0, 8'd13, 8'd1, 8'd9, m2, e2, bz);
        tests_run++;
        if (m1 !== 8'd3 || m2 !== 8'd1 || e1 != 10 || e2 != 10) begin
            failed++;
            $display("FAIL back_to_back: got m=%0d,%0d lat=%0d,%0d, need 3,1 lat 10,10", m1, m2, e1, e2);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        logic [7:0] m;
        int e, bz;
        @(negedge clk);
        n8 = 13; a8 = 12; b8 = 12; st8[0] = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        st8[0] = 1'b0;
        rst_n = 0;
        #1;
        tests_run++;
        if (m8[0] !== 8'd0 || busy8[0] !== 1'b0 || done8[0] !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid: got m=%0d busy=%b done=%b, need 0/0/0", m8[0], busy8[0], done8[0]);
        end
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            dones += int'(done8[0]);
        end
        tests_run++;
        if (dones != 0) begin
            failed++;
            $display("FAIL reset_no_done: got %0d done pulses, need 0", dones);
        end
        run8(0, 8'd13, 8'd5, 8'd7, m, e, bz);
        tests_run++;
        if (m !== 8'd1 || e != 10) begin
            failed++;
            $display("FAIL after_reset: got m=%0d lat=%0d, need m=1 lat=10", m, e);
        end
    endtask

    // result x is correct iff x < N and x*2^256 == a*b (mod N)
    task automatic test_w256();
        logic [255:0] n, a, b, m;
        logic [511:0] lhs, rhs;
        int e;
        for (int i = 0; i < 150; i++) begin
            if (i == 0) n = '1;
            else begin
                n = rand256() | 256'd1;
                if (n == 256'd1) n = 256'd3;
            end
            a = (i < 2) ? n - 1 : 256'(({256'b0, rand256()}) % {256'b0, n});
            b = (i < 2) ? n - 1 : 256'(({256'b0, rand256()}) % {256'b0, n});
            if (i == 1) b = 256'(({256'b0, rand256()}) % {256'b0, n});
            run256(n, a, b, m, e);
            lhs = {m, 256'b0} % {256'b0, n};
            rhs = ({256'b0, a} * {256'b0, b}) % {256'b0, n};
            tests_run++;
            if (lhs !== rhs || m >= n) begin
                failed++;
                $display("FAIL w256 run %0d: got m=%h, need m*R%%N=%h (N=%h)", i, m, rhs[255:0], n);
            end
            tests_run++;
            if (e != 258) begin
                failed++;
                $display("FAIL w256_lat run %0d: got %0d edges, need 258", i, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_iter();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_w256();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
